pipeline_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline (PC, IF, ID, EX, MEM, WB).

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state type and redirect-target helper for the pipeline
// stall/flush controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_IF   = 6'b000011;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [5:0]  STALL_ALL  = 6'b111111;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000E;

  // ERET returns to EPC; every other exception enters the common vector.
  function automatic logic [31:0] flush_target(input logic [31:0] exc_type,
                                               input logic [31:0] epc,
                                               input logic [31:0] exc_vector);
    return (exc_type == EXC_ERET) ? epc : exc_vector;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter: increments on each enabled edge, sticks at all-ones.
module pipeline_ctrl_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: merges stall requests, sequences exception
// and ERET flushes, and holds the pipe while an SRAM transaction drains.
//
// state    | meaning
// ST_RUN   | normal operation, outputs combinational from requests/exception
// ST_DRAIN | exception latched, whole pipe held until the bus goes idle
// ST_FLUSH | one-cycle flush with redirect PC from the latched exception
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if_i,
  input  logic             stallreq_id_i,
  input  logic             stallreq_ex_i,
  input  logic             stallreq_mem_i,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  input  logic             bus_busy_i,
  output logic [5:0]       stall_o,
  output logic             flush_o,
  output logic [31:0]      new_pc_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  state_t      state;
  state_t      state_next;
  logic        latch_en;
  logic [31:0] exc_type_q;
  logic [31:0] epc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_RUN;
      exc_type_q <= ZERO_WORD;
      epc_q      <= ZERO_WORD;
    end else begin
      state <= state_next;
      if (latch_en) begin
        exc_type_q <= excepttype_i;
        epc_q      <= cp0_epc_i;
      end
    end
  end

  // Outputs are gated by reset so the pipe sees no stall or flush while held in reset.
  always_comb begin
    stall_o    = STALL_NONE;
    flush_o    = 1'b0;
    new_pc_o   = ZERO_WORD;
    state_next = state;
    latch_en   = 1'b0;
    if (rst) begin
      unique case (state)
        ST_RUN: begin
          if (excepttype_i != ZERO_WORD) begin
            if (bus_busy_i) begin
              stall_o    = STALL_ALL;
              latch_en   = 1'b1;
              state_next = ST_DRAIN;
            end else begin
              flush_o  = 1'b1;
              new_pc_o = flush_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
            end
          end else if (stallreq_mem_i) begin
            stall_o = STALL_MEM;
          end else if (stallreq_ex_i) begin
            stall_o = STALL_EX;
          end else if (stallreq_id_i) begin
            stall_o = STALL_ID;
          end else if (stallreq_if_i) begin
            stall_o = STALL_IF;
          end
        end
        ST_DRAIN: begin
          stall_o = STALL_ALL;
          if (!bus_busy_i) begin
            state_next = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          flush_o    = 1'b1;
          new_pc_o   = flush_target(exc_type_q, epc_q, EXC_VECTOR);
          state_next = ST_RUN;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

  pipeline_ctrl_sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_o != STALL_NONE),
    .count(stall_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a behavioural model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_pipeline_ctrl;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
  logic [31:0] exc = '0;
  logic [31:0] epc = '0;
  logic        busy = 1'b0;

  logic [5:0]  stall, stall_s;
  logic        flush, flush_s;
  logic [31:0] new_pc, new_pc_s;
  logic [31:0] cnt;
  logic [3:0]  cnt_s;

  int vectors = 0;
  int miscompares = 0;
  logic run_chk = 1'b0;

  // Model state: an exception waiting for the bus, and a flush owed next cycle.
  logic        m_pend, m_flush;
  logic [31:0] m_type, m_epc;
  logic [31:0] m_cnt;
  logic [3:0]  m_cnt_s;
  exp_t        m_e;

  always #5 clk = ~clk;

  pipeline_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if_i(req_if), .stallreq_id_i(req_id),
    .stallreq_ex_i(req_ex), .stallreq_mem_i(req_mem),
    .excepttype_i(exc), .cp0_epc_i(epc), .bus_busy_i(busy),
    .stall_o(stall), .flush_o(flush), .new_pc_o(new_pc), .stall_cnt_o(cnt)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  pipeline_ctrl #(.EXC_VECTOR(32'hBFC0_0380), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .stallreq_if_i(req_if), .stallreq_id_i(req_id),
    .stallreq_ex_i(req_ex), .stallreq_mem_i(req_mem),
    .excepttype_i(exc), .cp0_epc_i(epc), .bus_busy_i(busy),
    .stall_o(stall_s), .flush_o(flush_s), .new_pc_o(new_pc_s), .stall_cnt_o(cnt_s)
  );

  function automatic logic [31:0] target(input logic [31:0] t, input logic [31:0] e);
    return (t == 32'hE) ? e : 32'hBFC0_0380;
  endfunction

  // A request from stage k holds that stage and everything upstream of it.
  function automatic logic [5:0] held_stages(input int n);
    return 6'((1 << n) - 1);
  endfunction

  function automatic exp_t model_out();
    exp_t r;
    int   n;
    r = '0;
    if (!rst) return r;
    if (m_flush) begin
      r.flush = 1'b1;
      r.pc    = target(m_type, m_epc);
    end else if (m_pend) begin
      r.stall = 6'h3F;
    end else if (exc != 0) begin
      if (busy) begin
        r.stall = 6'h3F;
      end else begin
        r.flush = 1'b1;
        r.pc    = target(exc, epc);
      end
    end else begin
      n = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
      r.stall = held_stages(n);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend  <= 1'b0;
      m_flush <= 1'b0;
      m_type  <= '0;
      m_epc   <= '0;
      m_cnt   <= '0;
      m_cnt_s <= '0;
    end else begin
      m_e = model_out();
      if (m_e.stall != 0) begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
        if (m_cnt_s != 4'hF) m_cnt_s <= m_cnt_s + 1;
      end
      if (m_flush) begin
        m_flush <= 1'b0;
      end else if (m_pend) begin
        if (!busy) begin
          m_pend  <= 1'b0;
          m_flush <= 1'b1;
        end
      end else if (exc != 0 && busy) begin
        m_pend <= 1'b1;
        m_type <= exc;
        m_epc  <= epc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (run_chk) begin
      e = model_out();
      chk("stall", {26'd0, stall}, {26'd0, e.stall});
      chk("flush", {31'd0, flush}, {31'd0, e.flush});
      chk("new_pc", new_pc, e.pc);
      chk("stall_cnt", cnt, m_cnt);
      chk("stall_s", {26'd0, stall_s}, {26'd0, e.stall});
      chk("flush_s", {31'd0, flush_s}, {31'd0, e.flush});
      chk("new_pc_s", new_pc_s, e.pc);
      chk("stall_cnt_s", {28'd0, cnt_s}, {28'd0, m_cnt_s});
    end
  end

  task automatic drv(input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                     input logic [31:0] t, input logic [31:0] e, input logic b);
    @(posedge clk);
    #1;
    req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
    exc = t; epc = e; busy = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    run_chk = 1'b1;
    // reset held with idle inputs
    drv(0, 0, 0, 0, 0, 0, 0);
    #3 chk("lit_reset_stall", {26'd0, stall}, 32'h0);
    chk("lit_reset_cnt", cnt, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    #3 chk("lit_idle_stall", {26'd0, stall}, 32'h0);

    // stall priority
    drv(0, 1, 1, 0, 0, 0, 0);
    #3 chk("lit_id_ex", {26'd0, stall}, 32'h0F);
    drv(1, 0, 0, 0, 0, 0, 0);
    #3 chk("lit_if_only", {26'd0, stall}, 32'h03);
    drv(1, 0, 0, 1, 0, 0, 0);
    #3 chk("lit_mem_if", {26'd0, stall}, 32'h1F);
    drv(0, 1, 0, 0, 0, 0, 0);
    #3 chk("lit_id_only", {26'd0, stall}, 32'h07);

    // immediate exception, also with a MEM stall request pending
    drv(0, 0, 0, 0, 32'h8, 32'h1111_2222, 0);
    #3 chk("lit_imm_flush", {31'd0, flush}, 32'h1);
    chk("lit_imm_pc", new_pc, 32'hBFC0_0380);
    chk("lit_imm_stall", {26'd0, stall}, 32'h0);
    drv(0, 0, 0, 1, 32'h8, 32'h0, 0);
    #3 chk("lit_prio_flush", {31'd0, flush}, 32'h1);
    chk("lit_prio_stall", {26'd0, stall}, 32'h0);
    drv(0, 0, 0, 0, 32'hE, 32'h8000_0040, 0);
    #3 chk("lit_imm_eret_pc", new_pc, 32'h8000_0040);

    // ERET with drain; EPC and requests changing during DRAIN are ignored
    drv(0, 0, 0, 0, 32'hE, 32'h8000_1234, 1);
    #3 chk("lit_drain0", {26'd0, stall}, 32'h3F);
    chk("lit_drain0_flush", {31'd0, flush}, 32'h0);
    drv(1, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 1);
    #3 chk("lit_drain1", {26'd0, stall}, 32'h3F);
    drv(0, 0, 0, 0, 32'h8, 32'hDEAD_BEEF, 1);
    #3 chk("lit_drain2", {26'd0, stall}, 32'h3F);
    drv(0, 0, 0, 0, 32'h0, 32'hDEAD_BEEF, 0);
    #3 chk("lit_drain3", {26'd0, stall}, 32'h3F);
    drv(0, 0, 1, 0, 32'h0, 32'hDEAD_BEEF, 0);
    #3 chk("lit_eret_flush", {31'd0, flush}, 32'h1);
    chk("lit_eret_pc", new_pc, 32'h8000_1234);
    chk("lit_eret_stall", {26'd0, stall}, 32'h0);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 0);
    #3 chk("lit_after_flush", {31'd0, flush}, 32'h0);

    // general exception with a one-cycle drain
    drv(0, 0, 0, 0, 32'h4, 32'h8000_5555, 1);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 0);
    drv(0, 0, 0, 0, 32'h0, 32'h0, 0);
    #3 chk("lit_exc_drain_pc", new_pc, 32'hBFC0_0380);

    // reset in the middle of a drain abandons the flush
    drv(0, 0, 0, 0, 32'h8, 32'h0, 1);
    drv(0, 0, 0, 0, 32'h8, 32'h0, 1);
    @(posedge clk); #1 rst = 1'b0;
    #3 chk("lit_rst_drain_stall", {26'd0, stall}, 32'h0);
    chk("lit_rst_drain_flush", {31'd0, flush}, 32'h0);
    chk("lit_rst_drain_pc", new_pc, 32'h0);
    chk("lit_rst_drain_cnt", cnt, 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    exc = 0; busy = 0;
    #3 chk("lit_rel_stall", {26'd0, stall}, 32'h0);
    drv(0, 0, 0, 0, 0, 0, 0);
    #3 chk("lit_rel_flush", {31'd0, flush}, 32'h0);

    // counter saturation: hold EX request
    for (int i = 0; i < 20; i++) drv(0, 0, 1, 0, 0, 0, 0);
    #3 chk("lit_cnt_19", cnt, 32'd19);
    chk("lit_cnt_s_sat", {28'd0, cnt_s}, 32'hF);
    drv(0, 0, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    #3 chk("lit_cnt_s_hold", {28'd0, cnt_s}, 32'hF);
    chk("lit_cnt_21", cnt, 32'd21);
    drv(0, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1 run_chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
